// File: rtl/muldiv_hilo_ctrl_pkg.sv
// Shared MIPS multiply/divide definitions: R-type funct encodings, controller states, default latencies.
package muldiv_hilo_ctrl_pkg;

  localparam int MUL_LAT_DEF  = 2;
  localparam int DIV_ITER_DEF = 32;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV_PREP,
    ST_DIV_ITER,
    ST_DIV_FIX,
    ST_DONE
  } state_t;

  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_radix2_iter.sv
// Iterative restoring divider, one quotient bit per enabled cycle after a start load.
// Latency: DIV_ITER enabled cycles; o_last flags the final iteration; no backpressure (caller gates i_en).
module div_radix2_iter #(
  parameter int DIV_ITER = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_en,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic [31:0] o_quo,
  output logic [31:0] o_rem,
  output logic        o_last
);

  localparam int CW = $clog2(DIV_ITER);

  logic [31:0]   r_rem;
  logic [31:0]   r_quo;
  logic [31:0]   r_div;
  logic [CW-1:0] r_cnt;
  logic [32:0]   w_part;
  logic [32:0]   w_diff;

  // Quotient register doubles as the dividend shift-out register.
  assign w_part = {r_rem, r_quo[31]};
  assign w_diff = w_part - {1'b0, r_div};
  assign o_quo  = r_quo;
  assign o_rem  = r_rem;
  assign o_last = i_en && (r_cnt == CW'(DIV_ITER - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rem <= '0;
      r_quo <= '0;
      r_div <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_rem <= '0;
      r_quo <= i_dividend;
      r_div <= i_divisor;
      r_cnt <= '0;
    end else if (i_en) begin
      if (!w_diff[32]) begin
        r_rem <= w_diff[31:0];
        r_quo <= {r_quo[30:0], 1'b1};
      end else begin
        r_rem <= w_part[31:0];
        r_quo <= {r_quo[30:0], 1'b0};
      end
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// E-stage multiply/divide sequencer owning HI/LO; MULT = MUL_LAT cycles, DIV = 34 cycles to DONE.
// Stalls F/D/E until DONE; commit waits out stall_M in DONE; flush aborts without writing HI/LO.
module muldiv_hilo_ctrl
  import muldiv_hilo_ctrl_pkg::*;
#(
  parameter int MUL_LAT  = MUL_LAT_DEF,
  parameter int DIV_ITER = DIV_ITER_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_E,
  input  logic        rtype_E,
  input  logic [5:0]  funct_E,
  input  logic [31:0] src_a_E,
  input  logic [31:0] src_b_E,
  input  logic        flush_E,
  input  logic        stall_M,
  output logic        muldiv_stall,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_hi, r_lo, r_res_hi, r_res_lo;
  logic [31:0] r_op_a, r_op_b;
  logic        r_mul_sgn, r_qneg, r_rneg;
  logic [3:0]  r_mul_cnt;
  logic        w_live, w_idle, w_signed;
  logic        w_acc_mul, w_acc_div, w_wr_hi, w_wr_lo, w_commit;
  logic        w_a_neg, w_b_neg, w_div_en, w_div_last;
  logic [31:0] w_a_abs, w_b_abs, w_quo, w_rem;
  logic [63:0] w_ma, w_mb, w_mprod;

  assign w_live    = valid_E & rtype_E & ~flush_E;
  assign w_idle    = (r_state == ST_IDLE);
  assign w_signed  = ~funct_E[0];
  assign w_acc_mul = w_live & w_idle & ((funct_E == FN_MULT) | (funct_E == FN_MULTU));
  assign w_acc_div = w_live & w_idle & ((funct_E == FN_DIV) | (funct_E == FN_DIVU));
  assign w_wr_hi   = w_live & w_idle & ~stall_M & (funct_E == FN_MTHI);
  assign w_wr_lo   = w_live & w_idle & ~stall_M & (funct_E == FN_MTLO);
  assign w_commit  = (r_state == ST_DONE) & ~flush_E & ~stall_M;

  assign w_a_neg = w_signed & src_a_E[31];
  assign w_b_neg = w_signed & src_b_E[31];
  assign w_a_abs = neg_if(w_a_neg, src_a_E);
  assign w_b_abs = neg_if(w_b_neg, src_b_E);

  // Low 64 bits of the 64x64 product of extended operands equal the exact 32x32 result.
  assign w_ma    = {{32{r_mul_sgn & r_op_a[31]}}, r_op_a};
  assign w_mb    = {{32{r_mul_sgn & r_op_b[31]}}, r_op_b};
  assign w_mprod = w_ma * w_mb;

  assign w_div_en = (r_state == ST_DIV_PREP) | (r_state == ST_DIV_ITER);

  div_radix2_iter #(.DIV_ITER(DIV_ITER)) u_div (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (w_acc_div),
    .i_en       (w_div_en),
    .i_dividend (w_a_abs),
    .i_divisor  (w_b_abs),
    .o_quo      (w_quo),
    .o_rem      (w_rem),
    .o_last     (w_div_last)
  );

  always_comb begin
    w_next       = r_state;
    muldiv_stall = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_acc_mul) begin
          w_next       = ST_MUL;
          muldiv_stall = 1'b1;
        end else if (w_acc_div) begin
          w_next       = ST_DIV_PREP;
          muldiv_stall = 1'b1;
        end
      end
      ST_MUL: begin
        if (flush_E) w_next = ST_IDLE;
        else begin
          muldiv_stall = 1'b1;
          if (r_mul_cnt == 4'(MUL_LAT - 2)) w_next = ST_DONE;
        end
      end
      ST_DIV_PREP: begin
        if (flush_E) w_next = ST_IDLE;
        else begin
          muldiv_stall = 1'b1;
          w_next       = ST_DIV_ITER;
        end
      end
      ST_DIV_ITER: begin
        if (flush_E) w_next = ST_IDLE;
        else begin
          muldiv_stall = 1'b1;
          if (w_div_last) w_next = ST_DIV_FIX;
        end
      end
      ST_DIV_FIX: begin
        if (flush_E) w_next = ST_IDLE;
        else begin
          muldiv_stall = 1'b1;
          w_next       = ST_DONE;
        end
      end
      ST_DONE: begin
        if (flush_E || !stall_M) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_res_hi  <= '0;
      r_res_lo  <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_mul_sgn <= 1'b0;
      r_mul_cnt <= '0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
    end else begin
      if (w_acc_mul) begin
        r_op_a    <= src_a_E;
        r_op_b    <= src_b_E;
        r_mul_sgn <= w_signed;
        r_mul_cnt <= '0;
      end
      if (r_state == ST_MUL) begin
        r_mul_cnt            <= r_mul_cnt + 1'b1;
        {r_res_hi, r_res_lo} <= w_mprod;
      end
      if (w_acc_div) begin
        r_qneg <= w_a_neg ^ w_b_neg;
        r_rneg <= w_a_neg;
      end
      if (r_state == ST_DIV_FIX) begin
        r_res_lo <= neg_if(r_qneg, w_quo);
        r_res_hi <= neg_if(r_rneg, w_rem);
      end
      if (w_commit) begin
        r_hi <= r_res_hi;
        r_lo <= r_res_lo;
      end else begin
        if (w_wr_hi) r_hi <= src_a_E;
        if (w_wr_lo) r_lo <= src_a_E;
      end
    end
  end

  assign busy   = ~w_idle;
  assign hi_out = r_hi;
  assign lo_out = r_lo;

endmodule

// File: doc/muldiv_hilo_ctrl.md
Name: muldiv_hilo_ctrl

Overview:
- Sequences the multi-cycle multiply/divide resource and owns the HI/LO architectural registers for the 5-stage MIPS core.
- Sits in the execute stage and consumes the R-type funct forwarded from decode (funct_to_alu path) plus the E-stage operands.
- Raises a pipeline stall while an operation is in flight and commits HI/LO exactly once per instruction.
- Honours exception/ERET flushes and downstream stalls.

Parameters:
- MUL_LAT, 2, cycles from MULT/MULTU acceptance to result ready (registered multiplier pipeline depth).
- DIV_ITER, 32, restoring-division iterations (one quotient bit per cycle).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- valid_E  in  1  E-stage holds a live instruction
- rtype_E  in  1  opcode == R_TYPE
- funct_E  in  6  instruction funct field
- src_a_E  in  32  rs operand (forwarded)
- src_b_E  in  32  rt operand (forwarded)
- flush_E  in  1  kill E-stage instruction (exception/ERET)
- stall_M  in  1  downstream stall; blocks commit
- muldiv_stall  out  1  hold F/D/E stages
- busy  out  1  FSM not IDLE
- hi_out  out  32  architectural HI
- lo_out  out  32  architectural LO

Behaviour:
- Reset: state=IDLE; hi_out=0, lo_out=0, muldiv_stall=0, busy=0; counters cleared.
- Decoded ops (only when rtype_E & valid_E & ~flush_E): MULT, MULTU, DIV, DIVU, MTHI, MTLO. MFHI/MFLO read hi_out/lo_out combinationally; no FSM action.
- MTHI/MTLO: single-cycle. HI or LO = src_a_E at the clock edge when ~stall_M. No stall asserted.
- FSM states: IDLE, MUL, DIV_PREP, DIV_ITER, DIV_FIX, DONE.
- IDLE -> MUL on MULT/MULTU. Operands latched. Signed vs unsigned selected by funct[0]. 64-bit product {HI,LO} ready after MUL_LAT cycles, then DONE.
- IDLE -> DIV_PREP on DIV/DIVU. Latch absolute values (signed) or raw operands (unsigned). Record quotient sign = a[31]^b[31] and remainder sign = a[31].
- DIV_PREP -> DIV_ITER.
- DIV_ITER: runs DIV_ITER cycles, shift-subtract, 33-bit partial remainder, counter 0..31. Exits to DIV_FIX when counter==31.
- DIV_FIX: conditional two's-complement negation of quotient/remainder, then DONE.
- Total DIV latency = 34 cycles acceptance-to-DONE.
- Divide by zero: no special path, fixed latency. Unsigned result is LO=0xFFFFFFFF, HI=dividend. Signed result follows the same datapath with sign fix applied; software treats it as UNPREDICTABLE.
- muldiv_stall: asserted combinationally in the acceptance cycle and every cycle until DONE; deasserted in DONE. Instruction leaves E on the DONE cycle.
- DONE: commit {HI,LO} at the edge when ~stall_M, then IDLE. If stall_M is high, hold DONE with muldiv_stall=0 and result retained; commit on the first ~stall_M edge.
- Flush mid-operation (flush_E=1 in any non-IDLE state): abort, next state IDLE, no HI/LO write, muldiv_stall=0 in that cycle.
- Flush in the acceptance cycle: op ignored.
- Reset mid-operation: immediate return to reset values, result discarded.
- New op accepted only in IDLE. The op following DONE arrives the next cycle and starts normally; no bubble beyond pipeline advance.
- MTHI/MTLO cannot coexist with busy, because the stall holds E.
- Arithmetic: signed MULT uses 64-bit sign-extended product. MULTU zero-extends. HI = remainder, LO = quotient.

Decomposition:
- Shared package (with defines2.vh constants): funct encodings (MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO), a state enum typedef, and DIV_ITER/MUL_LAT defaults.
- One sub-module: div_radix2_iter. Holds the iterative restoring divider datapath (partial remainder, quotient shift register, counter, start/done). The controller owns the FSM, sign handling, HI/LO registers and stall.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3 -> muldiv_stall high 2 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV a=-7, b=2 -> stall 34 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 100/7 -> LO=14, HI=2.
- DIVU a=0x12345678, b=0 -> 34-cycle latency; LO=0xFFFFFFFF, HI=0x12345678.
- DIV started with HI=0xAAAA0000, flush_E pulsed at iteration 10 -> FSM IDLE next cycle, stall drops, HI/LO unchanged.
- MULT reaches DONE with stall_M high for 3 cycles -> no commit until stall_M falls; single commit; muldiv_stall=0 throughout DONE.
- MTHI 0x5 followed immediately by MFHI -> hi_out=0x5 on the next cycle. Reset asserted mid-DIV -> hi_out=lo_out=0, busy=0 after the edge.
